// File: rtl/bitonic_sort_if.sv
// Handshake bundle for the bitonic sort controller: serial load in, sorted stream out.
`timescale 1ns/1ps
interface bitonic_sort_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bitonic_sort_ctrl.sv
// Time-multiplexed 8-entry bitonic sorter: load 8 bytes, run 24 compare-exchange
// steps through one shared comparator, then stream results largest first.
`timescale 1ns/1ps
module bitonic_sort_ctrl #(
  parameter int WIDTH  = 8,
  parameter int N_ELEM = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  bitonic_sort_if.slave  bus,
  output logic           busy
);
  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  localparam logic [2:0] LAST_IDX  = 3'(N_ELEM - 1);
  localparam logic [4:0] LAST_STEP = 5'd23;

  state_t                       state, state_nxt;
  logic [N_ELEM-1:0][WIDTH-1:0] mem;
  logic [2:0]                   ld_cnt, o_cnt;
  logic [4:0]                   s_cnt;
  logic                         out_valid, out_last;
  logic [WIDTH-1:0]             out_data;

  logic [1:0]       q;
  logic [2:0]       j, idx_i, idx_l;
  logic [3:0]       k;
  logic             desc, swap;
  logic [WIDTH-1:0] a, b;
  logic             ld_fire, o_fire;

  assign ld_fire = (state == LOAD) && bus.in_valid;
  assign o_fire  = (state == OUT) && out_valid && bus.out_ready;

  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;
  assign busy          = (state != LOAD);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next-state: 8 accepts, 24 sort steps, 8 output handshakes
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (ld_fire && ld_cnt == LAST_IDX) state_nxt = SORT;
      SORT:    if (s_cnt == LAST_STEP)            state_nxt = OUT;
      OUT:     if (o_fire && o_cnt == LAST_IDX)   state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Compare schedule: pass = s/4 picks (k,j); pair q picks the q-th i with bit j clear
  always_comb begin
    q     = s_cnt[1:0];
    j     = 3'd1;
    k     = 4'd8;
    idx_i = 3'd0;
    case (s_cnt[4:2])
      3'd0:    begin j = 3'd1; k = 4'd2; end
      3'd1:    begin j = 3'd2; k = 4'd4; end
      3'd2:    begin j = 3'd1; k = 4'd4; end
      3'd3:    begin j = 3'd4; k = 4'd8; end
      3'd4:    begin j = 3'd2; k = 4'd8; end
      default: begin j = 3'd1; k = 4'd8; end
    endcase
    // Insert a zero at bit position log2(j) so pairs come out in ascending i
    case (j)
      3'd1:    idx_i = {q, 1'b0};
      3'd2:    idx_i = {q[1], 1'b0, q[0]};
      default: idx_i = {1'b0, q};
    endcase
    idx_l = idx_i ^ j;
    // Blocks with (i & k) == 0 sort descending, so the final k=8 merge is descending
    desc  = ((k & {1'b0, idx_i}) == 4'd0);
    a     = mem[idx_i];
    b     = mem[idx_l];
    swap  = desc ? (a < b) : (a > b);
  end

  // Datapath: register file, counters and registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem       <= '0;
      ld_cnt    <= '0;
      s_cnt     <= '0;
      o_cnt     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (ld_fire) begin
            mem[ld_cnt] <= bus.in_data;
            ld_cnt      <= ld_cnt + 3'd1;
          end
        end
        SORT: begin
          if (swap) begin
            mem[idx_i] <= b;
            mem[idx_l] <= a;
          end
          s_cnt <= (s_cnt == LAST_STEP) ? 5'd0 : s_cnt + 5'd1;
        end
        OUT: begin
          // First OUT cycle only presents mem[0]; handshakes begin after that
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= mem[o_cnt];
            out_last  <= (o_cnt == LAST_IDX);
          end else if (bus.out_ready) begin
            if (o_cnt == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              o_cnt     <= 3'd0;
            end else begin
              o_cnt     <= o_cnt + 3'd1;
              out_data  <= mem[o_cnt + 3'd1];
              out_last  <= (o_cnt == LAST_IDX - 3'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Directed bench for bitonic_sort_ctrl: reset, sorting, handshakes, aborts, throughput.
`timescale 1ns/1ps
module tb_bitonic_sort_ctrl;
  typedef logic [7:0] vec_t [8];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   passed = 0;

  vec_t       got;
  logic [7:0] lastv;
  int         n_got, stall_err, stall_cnt;
  bit         timeout, load_ok;
  logic       in_ready_after, out_valid_after;
  time        first_acc_t, last_acc_t, first_valid_t;

  bitonic_sort_if #(.WIDTH(8)) bus ();

  bitonic_sort_ctrl #(.WIDTH(8), .N_ELEM(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Starts and ends at a negedge; optional random bubbles on in_valid
  task automatic load(input vec_t v, input bit gaps);
    int   idx;
    int   guard;
    logic rdy;
    logic drv;
    idx = 0;
    guard = 0;
    while (idx < 8 && guard < 200) begin
      drv = !(gaps && ($urandom_range(0, 2) == 0));
      bus.in_valid = drv;
      bus.in_data  = drv ? v[idx] : 8'hEE;
      rdy = bus.in_ready;
      @(posedge clk);
      if (drv && rdy) begin
        if (idx == 0) first_acc_t = $time;
        if (idx == 7) last_acc_t = $time;
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b0;
    load_ok = (idx == 8);
  endtask

  // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0,...
  task automatic collect(input int mode);
    int         it;
    logic       pv, pr, pl;
    logic [7:0] pd;
    bit         seen;
    it = 0; pv = 0; pr = 0; pl = 0; pd = 0; seen = 0;
    n_got = 0; stall_err = 0; stall_cnt = 0; lastv = '0;
    while (n_got < 8 && it < 300) begin
      bus.out_ready = (mode == 0) ? 1'b1 : ((it % 3) == 0);
      if (pv && !pr) begin
        stall_cnt++;
        if (!bus.out_valid || bus.out_data !== pd || bus.out_last !== pl) stall_err++;
      end
      if (bus.out_valid && !seen) begin
        seen = 1;
        first_valid_t = $time - 5;
      end
      if (bus.out_valid && bus.out_ready) begin
        got[n_got]   = bus.out_data;
        lastv[n_got] = bus.out_last;
        n_got++;
      end
      pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; pl = bus.out_last;
      @(posedge clk);
      @(negedge clk);
      it++;
    end
    timeout = (n_got < 8);
    in_ready_after  = bus.in_ready;
    out_valid_after = bus.out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    checks++; if (bus.out_data !== 8'd0) $display("FAIL reset_out_data got %0d exp 0", bus.out_data); else passed++;
    checks++; if (bus.out_last !== 1'b0) $display("FAIL reset_out_last got %b exp 0", bus.out_last); else passed++;
  endtask

  task automatic test_basic();
    vec_t v, e;
    v = '{3, 7, 1, 8, 2, 6, 5, 4};
    e = '{8, 7, 6, 5, 4, 3, 2, 1};
    load(v, 1'b0);
    checks++; if (load_ok !== 1'b1) $display("FAIL basic_load got %b exp 1", load_ok); else passed++;
    collect(0);
    checks++; if (timeout !== 1'b0) $display("FAIL basic_timeout got %0d outputs exp 8", n_got); else passed++;
    checks++; if ((first_valid_t - last_acc_t) !== 64'd250)
      $display("FAIL basic_latency got %0d ns exp 250 ns", first_valid_t - last_acc_t); else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== e[i]) $display("FAIL basic_out[%0d] got %0d exp %0d", i, got[i], e[i]); else passed++;
    end
    checks++; if (lastv !== 8'b1000_0000) $display("FAIL basic_last got %b exp 10000000", lastv); else passed++;
    checks++; if (in_ready_after !== 1'b1) $display("FAIL basic_in_ready_after got %b exp 1", in_ready_after); else passed++;
    checks++; if (out_valid_after !== 1'b0) $display("FAIL basic_out_valid_after got %b exp 0", out_valid_after); else passed++;
  endtask

  task automatic test_extremes();
    vec_t ins [3];
    vec_t exps [3];
    ins[0]  = '{255, 0, 255, 0, 128, 128, 1, 254};
    exps[0] = '{255, 255, 254, 128, 128, 1, 0, 0};
    ins[1]  = '{200, 150, 100, 90, 80, 40, 20, 5};
    exps[1] = '{200, 150, 100, 90, 80, 40, 20, 5};
    ins[2]  = '{11, 22, 33, 44, 55, 66, 77, 88};
    exps[2] = '{88, 77, 66, 55, 44, 33, 22, 11};
    for (int t = 0; t < 3; t++) begin
      load(ins[t], 1'b0);
      collect(0);
      checks++; if (timeout !== 1'b0) $display("FAIL ext%0d_timeout got %0d outputs exp 8", t, n_got); else passed++;
      for (int i = 0; i < 8; i++) begin
        checks++; if (got[i] !== exps[t][i])
          $display("FAIL ext%0d_out[%0d] got %0d exp %0d", t, i, got[i], exps[t][i]); else passed++;
      end
    end
  endtask

  task automatic test_gaps();
    vec_t v, e;
    v = '{10, 20, 30, 40, 50, 60, 70, 80};
    e = '{80, 70, 60, 50, 40, 30, 20, 10};
    load(v, 1'b1);
    checks++; if (load_ok !== 1'b1) $display("FAIL gaps_load got %b exp 1", load_ok); else passed++;
    // The first compare step fires on the next edge, so the file still holds load order
    for (int i = 0; i < 8; i++) begin
      checks++; if (dut.mem[i] !== v[i]) $display("FAIL gaps_mem[%0d] got %0d exp %0d", i, dut.mem[i], v[i]); else passed++;
    end
    collect(0);
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== e[i]) $display("FAIL gaps_out[%0d] got %0d exp %0d", i, got[i], e[i]); else passed++;
    end
  endtask

  task automatic test_stall();
    vec_t v, e;
    v = '{42, 17, 99, 3, 250, 64, 128, 5};
    e = '{250, 128, 99, 64, 42, 17, 5, 3};
    load(v, 1'b0);
    collect(1);
    checks++; if (n_got !== 8) $display("FAIL stall_count got %0d exp 8", n_got); else passed++;
    checks++; if (stall_cnt < 8) $display("FAIL stall_exercised got %0d stalls exp >=8", stall_cnt); else passed++;
    checks++; if (stall_err !== 0) $display("FAIL stall_stable got %0d changes exp 0", stall_err); else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== e[i]) $display("FAIL stall_out[%0d] got %0d exp %0d", i, got[i], e[i]); else passed++;
    end
    checks++; if (lastv !== 8'b1000_0000) $display("FAIL stall_last got %b exp 10000000", lastv); else passed++;
    checks++; if (out_valid_after !== 1'b0) $display("FAIL stall_extra_valid got %b exp 0", out_valid_after); else passed++;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_sort_ignore();
    vec_t v, e;
    v = '{100, 50, 60, 70, 10, 20, 30, 40};
    e = '{100, 70, 60, 50, 40, 30, 20, 10};
    load(v, 1'b0);
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL sort_in_ready got %b exp 0", bus.in_ready); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL sort_busy got %b exp 1", busy); else passed++;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    collect(0);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== e[i]) $display("FAIL ignore_out[%0d] got %0d exp %0d", i, got[i], e[i]); else passed++;
    end
  endtask

  task automatic test_async_reset();
    vec_t v;
    int   g;
    v = '{3, 7, 1, 8, 2, 6, 5, 4};
    load(v, 1'b0);
    bus.out_ready = 1'b0;
    g = 0;
    while (!bus.out_valid && g < 60) begin
      @(negedge clk);
      g++;
    end
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL async_pre_valid got %b exp 1", bus.out_valid); else passed++;
    checks++; if (bus.out_data !== 8'd8) $display("FAIL async_pre_data got %0d exp 8", bus.out_data); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL async_out_valid got %b exp 0", bus.out_valid); else passed++;
    checks++; if (bus.out_data !== 8'd0) $display("FAIL async_out_data got %0d exp 0", bus.out_data); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL async_busy got %b exp 0", busy); else passed++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL async_in_ready got %b exp 1", bus.in_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset_mid_sort();
    vec_t v, f, e;
    v = '{90, 91, 92, 93, 94, 95, 96, 97};
    f = '{9, 200, 3, 77, 77, 14, 250, 0};
    e = '{250, 200, 77, 77, 14, 9, 3, 0};
    load(v, 1'b0);
    repeat (10) @(posedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL midsort_busy_before got %b exp 1", busy); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL midsort_busy got %b exp 0", busy); else passed++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL midsort_in_ready got %b exp 1", bus.in_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    load(f, 1'b0);
    collect(0);
    checks++; if (timeout !== 1'b0) $display("FAIL midsort_timeout got %0d outputs exp 8", n_got); else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== e[i]) $display("FAIL midsort_out[%0d] got %0d exp %0d", i, got[i], e[i]); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    vec_t       v, e;
    logic [7:0] tmp;
    bus.out_ready = 1'b1;
    for (int bt = 0; bt < 3; bt++) begin
      for (int i = 0; i < 8; i++) v[i] = 8'($urandom_range(0, 255));
      e = v;
      for (int p = 0; p < 7; p++)
        for (int i = 0; i < 7 - p; i++)
          if (e[i] < e[i+1]) begin
            tmp = e[i]; e[i] = e[i+1]; e[i+1] = tmp;
          end
      load(v, 1'b0);
      collect(0);
      // Next accept can land on the edge after this negedge
      checks++; if (($time + 5 - first_acc_t) !== 64'd410)
        $display("FAIL b2b%0d_cycles got %0d ns exp 410 ns", bt, $time + 5 - first_acc_t); else passed++;
      for (int i = 0; i < 8; i++) begin
        checks++; if (got[i] !== e[i]) $display("FAIL b2b%0d_out[%0d] got %0d exp %0d", bt, i, got[i], e[i]); else passed++;
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_gaps();
    test_stall();
    test_sort_ignore();
    test_async_reset();
    test_reset_mid_sort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/bitonic_sort_ctrl.md
Name: bitonic_sort_ctrl

Overview:
- Time-multiplexed 8-entry bitonic sorter controller for the 8-bit bitonic sorting datapath.
- Accepts 8 bytes serially and stores them in an internal 8×8-bit register file.
- Sequences one shared compare-exchange unit through the full 24-step bitonic network (6 passes × 4 pairs).
- Streams the 8 results out in descending order over a valid/ready handshake.

Parameters:
- WIDTH, 8, data width of each element.
- N_ELEM, 8, element count. Fixed at 8; the compare schedule is hard-coded for 8.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data valid this cycle.
- in_data  input  WIDTH  element to load.
- in_ready  output  1  controller can accept an element.
- out_valid  output  1  out_data holds a sorted element.
- out_data  output  WIDTH  sorted element, largest first.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  high with the 8th (smallest) output element.
- busy  output  1  high in SORT and OUT states.

Behaviour:
- One clock domain. Reset is asynchronous and active-low (rst_n). All state is cleared immediately on rst_n low, regardless of clock.
- Reset values:
  - state = LOAD; in_ready = 1 once rst_n is released.
  - out_valid = 0, out_data = 0, out_last = 0, busy = 0.
  - Load, step and output counters = 0; register file = 0.
- States:
  - LOAD:
    - in_ready = 1.
    - On in_valid & in_ready: mem[ld_cnt] <= in_data; ld_cnt increments.
    - On the 8th accept (ld_cnt = 7): go to SORT next cycle, ld_cnt wraps to 0.
    - in_valid low inserts bubbles with no effect.
  - SORT:
    - in_ready = 0; busy = 1. One compare-exchange per cycle; step counter s runs 0..23.
    - Pass p (0..5) = s/4. Pass parameters (k, j): p0 (2,1), p1 (4,2), p2 (4,1), p3 (8,4), p4 (8,2), p5 (8,1).
    - Within a pass, the 4 pairs are taken in ascending order of i, over indices i with (i XOR j) > i; partner l = i XOR j.
    - If (i AND k) == 0, the larger value goes to mem[i] and the smaller to mem[l]. Otherwise the smaller goes to mem[i] and the larger to mem[l].
    - Ties: no swap. Comparison is unsigned.
    - Exactly 24 cycles in SORT, then OUT.
    - Result: mem[0] >= mem[1] >= ... >= mem[7].
  - OUT:
    - out_valid = 1 and out_data = mem[o_cnt], registered.
    - On out_valid & out_ready: o_cnt increments.
    - out_last = 1 when o_cnt = 7.
    - Accepting the last element returns to LOAD the next cycle: out_valid drops, in_ready rises.
    - out_ready low holds out_data and out_last stable (no change while stalled).
- Latency:
  - First out_valid is asserted 25 cycles after the cycle that accepts the 8th input: 24 SORT cycles plus 1 registered transition.
  - With out_ready held high, throughput is 8 + 24 + 1 + 8 = 41 cycles per batch.
- No overlap: inputs are not accepted during SORT or OUT. in_valid there is ignored and the data is not stored.
- Reset mid-SORT or mid-OUT aborts the batch. Partial data is discarded and the controller restarts in LOAD with counters zeroed.
- Duplicates: equal values are all kept; the output multiset equals the input multiset.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release -> in_ready=1, out_valid=0, busy=0, out_data=0. Assert rst_n low mid-cycle -> outputs clear without waiting for a clock edge.
- Basic sort: load 3,7,1,8,2,6,5,4 back-to-back with out_ready=1 -> out_valid rises exactly 25 cycles after the 8th accept. Outputs are 8,7,6,5,4,3,2,1; out_last only on 1; in_ready returns 1 the cycle after.
- Extremes and ties: load 255,0,255,0,128,128,1,254 -> outputs 255,255,254,128,128,1,0,0. Also check already-descending and already-ascending inputs.
- Handshake stress:
  - Insert random in_valid gaps -> all 8 values still stored in order.
  - Toggle out_ready 1,0,0,1,... -> out_data is stable while stalled, no element is dropped or duplicated, and the count is exactly 8.
  - in_valid=1 with data 0x55 during SORT -> ignored, result unchanged.
- Reset mid-operation: pulse rst_n low at SORT step 10 -> busy=0, in_ready=1. Then load 8 fresh values -> correct descending output with no residue from the aborted batch.
- Back-to-back batches: 3 consecutive random batches with out_ready=1 -> each batch takes 41 cycles, and every output matches a reference model (descending sort).
